// File: rtl/irs_block_readout_sequencer_pkg.sv
// Shared block-info entry layout, header constants and sequencer
// state codes; the event controller packs entries with the same offsets.
package irs_block_readout_sequencer_pkg;

  localparam int SCAL_NUM_L4 = 4;

  localparam int BI_BLOCK = 0;
  localparam int BI_NEW   = 9;
  localparam int BI_L4    = 10;
  localparam int BI_L4NEW = 16;
  localparam int BI_SEC   = 24;
  localparam int BI_CYC   = 40;

  localparam logic [15:0] EVT_HDR_ID = 16'hE7E7;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LATCH     = 3'd1;
  localparam logic [2:0] S_EVHDR     = 3'd2;
  localparam logic [2:0] S_BLKHDR    = 3'd3;
  localparam logic [2:0] S_READ      = 3'd4;
  localparam logic [2:0] S_READ_WAIT = 3'd5;
  localparam logic [2:0] S_FREE      = 3'd6;

  typedef struct packed {
    logic [31:0] cycles;
    logic [15:0] second;
    logic [5:0]  l4_new;
    logic [5:0]  l4;
    logic        new_event;
    logic [8:0]  block;
  } bi_entry_t;

  // Trigger fields wider than n are forced to zero.
  function automatic bi_entry_t bi_decode(
    input logic [71:0] d,
    input int          n
  );
    bi_entry_t e;
    e = '0;
    e.block     = d[BI_BLOCK +: 9];
    e.new_event = d[BI_NEW];
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        e.l4[i]     = d[BI_L4 + i];
        e.l4_new[i] = d[BI_L4NEW + i];
      end
    end
    e.second = d[BI_SEC +: 16];
    e.cycles = d[BI_CYC +: 32];
    return e;
  endfunction

endpackage

// File: rtl/irs_block_readout_sequencer_hdr_word_mux.sv
// Header word selection for the event and block headers, with
// back-pressure from the header FIFO full flag.
module irs_hdr_word_mux #(
  parameter logic [15:0] HDR_ID = 16'hE7E7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evhdr,
  input  logic        blkhdr,
  input  logic        hdr_full,
  input  logic [15:0] event_num,
  input  logic [15:0] second,
  input  logic [31:0] cycles,
  input  logic [15:0] blk_word,
  output logic [15:0] hdr_dat,
  output logic        hdr_wr,
  output logic        ev_done,
  output logic        blk_done
);

  localparam logic [2:0] W_LAST = 3'd4;

  logic [2:0] idx_q;

  assign hdr_wr   = (evhdr | blkhdr) & ~hdr_full;
  assign ev_done  = evhdr & hdr_wr & (idx_q == W_LAST);
  assign blk_done = blkhdr & hdr_wr;

  always_comb begin
    hdr_dat = '0;
    if (evhdr) begin
      unique case (idx_q)
        3'd0:    hdr_dat = HDR_ID;
        3'd1:    hdr_dat = event_num;
        3'd2:    hdr_dat = second;
        3'd3:    hdr_dat = cycles[31:16];
        3'd4:    hdr_dat = cycles[15:0];
        default: hdr_dat = '0;
      endcase
    end else if (blkhdr) begin
      hdr_dat = blk_word;
    end
  end

  // A stalled word keeps its index so it is neither lost nor repeated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (evhdr && hdr_wr) begin
      idx_q <= (idx_q == W_LAST) ? 3'd0 : idx_q + 3'd1;
    end
  end

endmodule

// File: rtl/irs_block_readout_sequencer.sv
// Pops block-info entries, emits event/block headers, then drives
// the readout and free handshakes for one block at a time.
module irs_block_readout_sequencer #(
  parameter int NUM_L4 =
    irs_block_readout_sequencer_pkg::SCAL_NUM_L4,
  parameter int READ_TIMEOUT = 1023,
  parameter logic [15:0] EVT_HDR_ID =
    irs_block_readout_sequencer_pkg::EVT_HDR_ID
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [71:0] irs_buff_dat_i,
  input  logic        irs_buff_empty_i,
  output logic        irs_buff_read_o,
  output logic        readout_req_o,
  output logic [8:0]  readout_block_o,
  input  logic        readout_ack_i,
  output logic        free_req_o,
  output logic [8:0]  free_block_o,
  input  logic        free_ack_i,
  output logic [15:0] hdr_dat_o,
  output logic        hdr_wr_o,
  input  logic        hdr_full_i,
  output logic [15:0] event_count_o,
  output logic        busy_o,
  output logic        err_orphan_o,
  output logic        err_timeout_o
);

  import irs_block_readout_sequencer_pkg::*;

  localparam logic [9:0] TMO_LAST = 10'(READ_TIMEOUT - 1);

  logic [2:0]  state_q;
  logic        run_q;
  logic        seen_q;
  bi_entry_t   ent_q;
  bi_entry_t   ent_d;
  logic [9:0]  tmo_q;
  logic [15:0] evt_cnt_q;
  logic        rd_req_q;
  logic        fr_req_q;
  logic        err_orph_q;
  logic        err_tmo_q;
  logic        pop;
  logic        ev_done;
  logic        blk_done;
  logic [15:0] blk_word;
  logic        unused_bits;

  assign ent_d = bi_decode(irs_buff_dat_i, NUM_L4);

  // run_q keeps the pop strobe low while reset is held.
  assign pop = run_q & (state_q == S_IDLE)
             & enable_i & ~irs_buff_empty_i;

  assign blk_word = {ent_q.l4_new, ent_q.new_event,
                     ent_q.block};

  assign irs_buff_read_o = pop;
  assign readout_req_o   = rd_req_q;
  assign readout_block_o = ent_q.block & {9{rd_req_q}};
  assign free_req_o      = fr_req_q;
  assign free_block_o    = ent_q.block & {9{fr_req_q}};
  assign event_count_o   = evt_cnt_q;
  assign busy_o          = (state_q != S_IDLE);
  assign err_orphan_o    = err_orph_q;
  assign err_timeout_o   = err_tmo_q;

  // l4 is carried for a future trigger-info word only.
  assign unused_bits = ^{irs_buff_dat_i, ent_q.l4};

  irs_hdr_word_mux #(
    .HDR_ID(EVT_HDR_ID)
  ) u_hdr (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .evhdr    (state_q == S_EVHDR),
    .blkhdr   (state_q == S_BLKHDR),
    .hdr_full (hdr_full_i),
    .event_num(evt_cnt_q),
    .second   (ent_q.second),
    .cycles   (ent_q.cycles),
    .blk_word (blk_word),
    .hdr_dat  (hdr_dat_o),
    .hdr_wr   (hdr_wr_o),
    .ev_done  (ev_done),
    .blk_done (blk_done)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      seen_q     <= 1'b0;
      ent_q      <= '0;
      tmo_q      <= '0;
      evt_cnt_q  <= '0;
      rd_req_q   <= 1'b0;
      fr_req_q   <= 1'b0;
      err_orph_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (pop) state_q <= S_LATCH;
        end
        S_LATCH: begin
          ent_q <= ent_d;
          if (ent_d.new_event) begin
            evt_cnt_q <= evt_cnt_q + 16'd1;
            seen_q    <= 1'b1;
            state_q   <= S_EVHDR;
          end else begin
            if (!seen_q) err_orph_q <= 1'b1;
            state_q <= S_BLKHDR;
          end
        end
        S_EVHDR: begin
          if (ev_done) state_q <= S_BLKHDR;
        end
        S_BLKHDR: begin
          if (blk_done) begin
            rd_req_q <= 1'b1;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          tmo_q <= '0;
          if (readout_ack_i) begin
            rd_req_q <= 1'b0;
            fr_req_q <= 1'b1;
            state_q  <= S_FREE;
          end else begin
            state_q <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (readout_ack_i) begin
            rd_req_q <= 1'b0;
            fr_req_q <= 1'b1;
            state_q  <= S_FREE;
          end else if (tmo_q == TMO_LAST) begin
            err_tmo_q <= 1'b1;
            rd_req_q  <= 1'b0;
            fr_req_q  <= 1'b1;
            state_q   <= S_FREE;
          end else begin
            tmo_q <= tmo_q + 10'd1;
          end
        end
        S_FREE: begin
          if (free_ack_i) begin
            fr_req_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irs_block_readout_sequencer.sv
// Random and directed bench for the block readout sequencer,
// scored against an entry-level header/readout/free model.
module tb_irs_block_readout_sequencer;

  localparam int NL4 = 4;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic [71:0] irs_buff_dat_i;
  logic        irs_buff_empty_i;
  logic        irs_buff_read_o;
  logic        readout_req_o;
  logic [8:0]  readout_block_o;
  logic        readout_ack_i;
  logic        free_req_o;
  logic [8:0]  free_block_o;
  logic        free_ack_i;
  logic [15:0] hdr_dat_o;
  logic        hdr_wr_o;
  logic        hdr_full_i;
  logic [15:0] event_count_o;
  logic        busy_o;
  logic        err_orphan_o;
  logic        err_timeout_o;

  always #5 clk = ~clk;

  irs_block_readout_sequencer #(
    .NUM_L4(NL4)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .enable_i        (enable_i),
    .irs_buff_dat_i  (irs_buff_dat_i),
    .irs_buff_empty_i(irs_buff_empty_i),
    .irs_buff_read_o (irs_buff_read_o),
    .readout_req_o   (readout_req_o),
    .readout_block_o (readout_block_o),
    .readout_ack_i   (readout_ack_i),
    .free_req_o      (free_req_o),
    .free_block_o    (free_block_o),
    .free_ack_i      (free_ack_i),
    .hdr_dat_o       (hdr_dat_o),
    .hdr_wr_o        (hdr_wr_o),
    .hdr_full_i      (hdr_full_i),
    .event_count_o   (event_count_o),
    .busy_o          (busy_o),
    .err_orphan_o    (err_orphan_o),
    .err_timeout_o   (err_timeout_o)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [71:0] fifo_q[$];
  logic [15:0] hdr_q[$];
  logic [8:0]  rd_q[$];
  logic [8:0]  fr_q[$];

  logic [15:0] m_cnt;
  bit m_seen, m_orph, m_tmo;

  bit prev_read, prev_rreq, prev_freq;
  bit rd_acked, fr_acked, rd_ack_now, fr_ack_now;
  bit rd_ack_prev, fr_ack_prev, rd_got_ack;
  int rd_lat, fr_lat, rreq_len;
  bit ack_en, noack_once, rand_full, rand_en, spur, stall_arm;
  int stall_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [8:0] blk, input bit nw,
                      input logic [5:0] l4, input logic [5:0] l4n,
                      input logic [15:0] sec, input logic [31:0] cy);
    logic [71:0] d;
    logic [5:0]  l4n_vis;
    d = '0;
    d[8:0]   = blk;
    d[9]     = nw;
    d[15:10] = l4;
    d[21:16] = l4n;
    d[23:22] = 2'($urandom);
    d[39:24] = sec;
    d[71:40] = cy;
    fifo_q.push_back(d);
    l4n_vis = l4n & 6'((1 << NL4) - 1);
    if (nw) begin
      m_cnt  = m_cnt + 16'd1;
      m_seen = 1'b1;
      hdr_q.push_back(16'hE7E7);
      hdr_q.push_back(m_cnt);
      hdr_q.push_back(sec);
      hdr_q.push_back(cy[31:16]);
      hdr_q.push_back(cy[15:0]);
    end else if (!m_seen) begin
      m_orph = 1'b1;
    end
    hdr_q.push_back({l4n_vis, nw, blk});
    rd_q.push_back(blk);
    fr_q.push_back(blk);
  endtask

  task automatic push_rand(input bit nw);
    push(9'($urandom), nw, 6'($urandom), 6'($urandom),
         16'($urandom), $urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    readout_ack_i = 1'b0;
    free_ack_i    = 1'b0;
    rd_ack_now    = 1'b0;
    fr_ack_now    = 1'b0;
    if (prev_read) begin
      if (fifo_q.size() > 0) irs_buff_dat_i = fifo_q.pop_front();
      else check("pop_empty", 32'(1), 32'(0));
    end
    irs_buff_empty_i = (fifo_q.size() == 0);
    enable_i = rand_en ? ($urandom_range(0, 4) != 0) : 1'b1;
    if (stall_cnt > 0) begin
      hdr_full_i = 1'b1;
      stall_cnt--;
    end else begin
      hdr_full_i = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (!readout_req_o) begin
      rd_acked = 1'b0;
      rd_lat   = $urandom_range(0, 4);
      if (spur && $urandom_range(0, 7) == 0) readout_ack_i = 1'b1;
    end else if (ack_en && !noack_once && !rd_acked) begin
      if (rd_lat == 0) begin
        readout_ack_i = 1'b1;
        rd_acked      = 1'b1;
        rd_ack_now    = 1'b1;
      end else rd_lat--;
    end
    if (!free_req_o) begin
      fr_acked = 1'b0;
      fr_lat   = $urandom_range(0, 4);
      if (spur && $urandom_range(0, 7) == 0) free_ack_i = 1'b1;
    end else if (!fr_acked) begin
      if (fr_lat == 0) begin
        free_ack_i = 1'b1;
        fr_acked   = 1'b1;
        fr_ack_now = 1'b1;
      end else fr_lat--;
    end
    #1;
    if (rd_ack_prev) check("rreq_drop", 32'(readout_req_o), 32'(0));
    if (fr_ack_prev) check("freq_drop", 32'(free_req_o), 32'(0));
    rd_ack_prev = rd_ack_now;
    fr_ack_prev = fr_ack_now;
    if (hdr_wr_o) begin
      check("wr_when_full", 32'(hdr_full_i), 32'(0));
      if (hdr_q.size() == 0) check("hdr_extra", 32'(1), 32'(0));
      else check("hdr_word", 32'(hdr_dat_o), 32'(hdr_q.pop_front()));
      if (stall_arm) begin
        stall_arm = 1'b0;
        stall_cnt = 7;
      end
    end
    if (readout_req_o && !prev_rreq) begin
      rreq_len   = 0;
      rd_got_ack = 1'b0;
      if (rd_q.size() == 0) check("rreq_extra", 32'(1), 32'(0));
      else check("rreq_block", 32'(readout_block_o),
                 32'(rd_q.pop_front()));
    end
    if (readout_req_o) rreq_len++;
    if (rd_ack_now) rd_got_ack = 1'b1;
    if (!readout_req_o && prev_rreq && !rd_got_ack) begin
      check("tmo_len",
            32'(rreq_len >= 1023 && rreq_len <= 1025), 32'(1));
      check("tmo_flag", 32'(err_timeout_o), 32'(1));
      m_tmo      = 1'b1;
      noack_once = 1'b0;
    end
    if (free_req_o && !prev_freq) begin
      if (fr_q.size() == 0) check("freq_extra", 32'(1), 32'(0));
      else check("freq_block", 32'(free_block_o),
                 32'(fr_q.pop_front()));
    end
    prev_read = irs_buff_read_o;
    prev_rreq = readout_req_o;
    prev_freq = free_req_o;
  endtask

  task automatic run(input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = fifo_q.size() == 0 && hdr_q.size() == 0 &&
             rd_q.size() == 0 && fr_q.size() == 0 &&
             !busy_o && !prev_read && !free_req_o;
    end
    if (!done) check("run_budget", 32'(n), 32'(0));
    check("evt_count", 32'(event_count_o), 32'(m_cnt));
    check("orphan", 32'(err_orphan_o), 32'(m_orph));
    check("timeout", 32'(err_timeout_o), 32'(m_tmo));
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    check("rst_read", 32'(irs_buff_read_o), 32'(0));
    check("rst_rreq", 32'(readout_req_o), 32'(0));
    check("rst_rblk", 32'(readout_block_o), 32'(0));
    check("rst_freq", 32'(free_req_o), 32'(0));
    check("rst_fblk", 32'(free_block_o), 32'(0));
    check("rst_hdat", 32'(hdr_dat_o), 32'(0));
    check("rst_hwr", 32'(hdr_wr_o), 32'(0));
    check("rst_cnt", 32'(event_count_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_orph", 32'(err_orphan_o), 32'(0));
    check("rst_tmo", 32'(err_timeout_o), 32'(0));
    fifo_q.delete();
    hdr_q.delete();
    rd_q.delete();
    fr_q.delete();
    m_cnt = '0; m_seen = 0; m_orph = 0; m_tmo = 0;
    prev_read = 0; prev_rreq = 0; prev_freq = 0;
    rd_acked = 0; fr_acked = 0; rd_ack_prev = 0; fr_ack_prev = 0;
    rd_got_ack = 0; noack_once = 0; stall_cnt = 0; stall_arm = 0;
    readout_ack_i = 1'b0;
    free_ack_i    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n_i = 1'b1;
  endtask

  initial begin
    int n;
    rst_n_i = 1'b0;
    enable_i = 1'b1;
    irs_buff_dat_i = '0;
    irs_buff_empty_i = 1'b0;
    readout_ack_i = 1'b0;
    free_ack_i = 1'b0;
    hdr_full_i = 1'b0;
    ack_en = 1; rand_full = 0; rand_en = 0; spur = 0;
    #3;
    do_reset();

    push(9'h055, 1'b0, 6'h0, 6'h0, 16'h0, 32'h0);
    run(200);

    push(9'h01A, 1'b1, 6'h0, 6'h0, 16'h1234, 32'hDEADBEEF);
    run(200);

    push(9'h100, 1'b1, 6'h3F, 6'h3F, 16'hABCD, 32'h01234567);
    push(9'h0FF, 1'b0, 6'h15, 6'h0A, 16'h0, 32'h0);
    push(9'h1FF, 1'b0, 6'h2A, 6'h05, 16'h0, 32'h0);
    run(400);

    stall_arm = 1'b1;
    push(9'h0C3, 1'b1, 6'h1, 6'h2, 16'h5A5A, 32'hCAFEF00D);
    run(200);

    noack_once = 1'b1;
    push(9'h111, 1'b1, 6'h0, 6'h1, 16'h0042, 32'h00010002);
    push(9'h122, 1'b0, 6'h0, 6'h0, 16'h0, 32'h0);
    run(2000);

    rand_full = 1; rand_en = 1; spur = 1;
    for (int i = 0; i < 40; i++) push_rand($urandom_range(0, 2) == 0);
    run(4000);
    rand_full = 0; rand_en = 0; spur = 0;

    noack_once = 1'b1;
    push_rand(1'b1);
    n = 0;
    while (!(readout_req_o && rreq_len > 5) && n < 200) begin
      tick();
      n++;
    end
    check("reach_wait", 32'(readout_req_o), 32'(1));
    #1;
    do_reset();

    push(9'h077, 1'b1, 6'h0, 6'h3, 16'h0777, 32'h77777777);
    run(200);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
